// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with registered valid/ready output and word address counter
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2:0]        i_op_class,
  input  logic [1:0]        i_alu_op,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_instr,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] CL_R      = 3'd0;
  localparam logic [2:0] CL_I      = 3'd1;
  localparam logic [2:0] CL_LOAD   = 3'd2;
  localparam logic [2:0] CL_STORE  = 3'd3;
  localparam logic [2:0] CL_BRANCH = 3'd4;
  localparam logic [2:0] CL_JAL    = 3'd5;
  localparam logic [2:0] CL_JALR   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_SUB = 2'b01;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic        w_accept;
  logic        w_fire;
  logic [2:0]  w_alu_f3;
  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_range_bad;
  logic        w_misalign;
  logic [1:0]  w_code;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;

  // A slot frees up when empty or draining this cycle; clear blocks intake
  assign o_in_ready  = !i_clear && (!r_valid || i_out_ready);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_fire      = r_valid && i_out_ready;

  assign o_out_valid = r_valid;
  assign o_out_instr = r_instr;
  assign o_out_addr  = r_addr;
  assign o_err       = r_err;
  assign o_err_code  = r_err_code;

  // Signed immediate fits when all bits above the field's sign bit match it
  assign w_fit12 = (i_imm[31:11] == '0) || (&i_imm[31:11]);
  assign w_fit13 = (i_imm[31:12] == '0) || (&i_imm[31:12]);
  assign w_fit21 = (i_imm[31:20] == '0) || (&i_imm[31:20]);

  // funct3 for the ALU ops shared by R and I classes
  always_comb begin
    w_alu_f3 = 3'b000;
    case (i_alu_op)
      2'b10:   w_alu_f3 = 3'b111;
      2'b11:   w_alu_f3 = 3'b110;
      default: w_alu_f3 = 3'b000;
    endcase
  end

  // Build the machine word and classify the request's problems
  always_comb begin
    w_word      = '0;
    w_illegal   = 1'b0;
    w_range_bad = 1'b0;
    w_misalign  = 1'b0;
    case (i_op_class)
      CL_R: begin
        w_word = {(i_alu_op == ALU_SUB) ? 7'b0100000 : 7'b0000000,
                  i_rs2, i_rs1, w_alu_f3, i_rd, OP_R};
      end
      CL_I: begin
        w_illegal   = (i_alu_op == ALU_SUB);
        w_range_bad = !w_fit12;
        w_word      = {i_imm[11:0], i_rs1, w_alu_f3, i_rd, OP_I};
      end
      CL_LOAD: begin
        w_range_bad = !w_fit12;
        w_word      = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LOAD};
      end
      CL_STORE: begin
        w_range_bad = !w_fit12;
        w_word      = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_STORE};
      end
      CL_BRANCH: begin
        w_range_bad = !w_fit13;
        w_misalign  = i_imm[0];
        w_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000,
                       i_imm[4:1], i_imm[11], OP_BRANCH};
      end
      CL_JAL: begin
        w_range_bad = !w_fit21;
        w_misalign  = i_imm[0];
        w_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      end
      CL_JALR: begin
        w_range_bad = !w_fit12;
        w_word      = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Highest-priority error wins; zero means the request encodes cleanly
  always_comb begin
    w_code = 2'b00;
    if (w_illegal)        w_code = 2'b01;
    else if (w_range_bad) w_code = 2'b10;
    else if (w_misalign)  w_code = 2'b11;
  end

  // Output slot: load a clean word on accept, empty it when drained
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (w_accept && (w_code == 2'b00)) begin
      r_valid <= 1'b1;
      r_instr <= w_word;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

  // Word address advances once per delivered word, wrapping naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= LP_BASE;
    end else if (i_clear) begin
      r_addr <= LP_BASE;
    end else if (w_fire) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Sticky error flag; the code of the first error is kept until clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else if (i_clear) begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else if (w_accept && (w_code != 2'b00)) begin
      r_err <= 1'b1;
      if (!r_err) r_err_code <= w_code;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder with a behavioural reference model
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op_class;
  logic [1:0]    alu_op;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [1:0]    err_code;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_addr;
  bit          m_err;
  logic [1:0]  m_code;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (clear),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op_class  (op_class),
    .i_alu_op    (alu_op),
    .i_rd        (rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_imm       (imm),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_instr (out_instr),
    .o_out_addr  (out_addr),
    .o_err       (err),
    .o_err_code  (err_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Encoding from the ISA field layout using integer arithmetic and signed ranges
  function automatic void ref_encode(input logic [2:0] cls, input logic [1:0] op,
                                     input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [31:0] im,
                                     output logic [31:0] w, output logic [1:0] code);
    logic [31:0] vd, v1, v2, f3;
    int s;
    int lo;
    int hi;
    bit illegal;
    bit ranged;
    bit need_even;
    vd = 32'(d); v1 = 32'(s1); v2 = 32'(s2);
    s = im;
    illegal = 0; ranged = 1; need_even = 0;
    lo = -2048; hi = 2047;
    f3 = (op == 2'd2) ? 32'd7 : (op == 2'd3) ? 32'd6 : 32'd0;
    w = 0;
    case (cls)
      3'd0: begin
        ranged = 0;
        w = ((op == 2'd1) ? 32'h4000_0000 : 32'h0) + (v2 << 20) + (v1 << 15) + (f3 << 12) + (vd << 7) + 32'h33;
      end
      3'd1: begin
        illegal = (op == 2'd1);
        w = ((im & 32'hFFF) << 20) + (v1 << 15) + (f3 << 12) + (vd << 7) + 32'h13;
      end
      3'd2: w = ((im & 32'hFFF) << 20) + (v1 << 15) + (32'd2 << 12) + (vd << 7) + 32'h03;
      3'd3: w = (((im >> 5) & 32'h7F) << 25) + (v2 << 20) + (v1 << 15) + (32'd2 << 12)
                + ((im & 32'h1F) << 7) + 32'h23;
      3'd4: begin
        lo = -4096; hi = 4095; need_even = 1;
        w = (((im >> 12) & 1) << 31) + (((im >> 5) & 32'h3F) << 25) + (v2 << 20) + (v1 << 15)
            + (((im >> 1) & 32'hF) << 8) + (((im >> 11) & 1) << 7) + 32'h63;
      end
      3'd5: begin
        lo = -(1 << 20); hi = (1 << 20) - 1; need_even = 1;
        w = (((im >> 20) & 1) << 31) + (((im >> 1) & 32'h3FF) << 21) + (((im >> 11) & 1) << 20)
            + (((im >> 12) & 32'hFF) << 12) + (vd << 7) + 32'h6F;
      end
      3'd6: w = ((im & 32'hFFF) << 20) + (v1 << 15) + (vd << 7) + 32'h67;
      default: illegal = 1;
    endcase
    if (illegal)                          code = 2'd1;
    else if (ranged && (s < lo || s > hi)) code = 2'd2;
    else if (need_even && (s % 2 != 0))   code = 2'd3;
    else                                  code = 2'd0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_instr = 0; m_addr = 0; m_err = 0; m_code = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check_eq({tag, ".addr"}, 32'(out_addr), 32'(m_addr));
    check_eq({tag, ".err"}, 32'(err), 32'(m_err));
    check_eq({tag, ".code"}, 32'(err_code), 32'(m_code));
    if (m_valid) check_eq({tag, ".instr"}, out_instr, m_instr);
  endtask

  // One clock: entered and left at a falling edge
  task automatic cycle(input string tag, input bit v, input logic [2:0] cls, input logic [1:0] op,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im, input bit ordy, input bit clr);
    bit exp_ready, acc, fire;
    logic [31:0] w;
    logic [1:0] code;
    in_valid = v; op_class = cls; alu_op = op; rd = d; rs1 = s1; rs2 = s2;
    imm = im; out_ready = ordy; clear = clr;
    #1;
    exp_ready = !clr && (!m_valid || ordy);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    fire = m_valid && ordy;
    ref_encode(cls, op, d, s1, s2, im, w, code);
    if (clr) begin
      m_valid = 0; m_addr = 0; m_err = 0; m_code = 0;
    end else begin
      if (fire) m_addr = (m_addr + 1) % (1 << AW);
      if (acc && code == 0) begin
        m_valid = 1; m_instr = w;
      end else if (fire) begin
        m_valid = 0;
      end
      if (acc && code != 0) begin
        if (!m_err) m_code = code;
        m_err = 1;
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [31:0] pick_imm();
    int b[12] = '{-2048, 2047, -2049, 2048, -4096, 4095, -4097, 4096,
                  -(1 << 20), (1 << 20) - 1, -(1 << 20) - 1, (1 << 20)};
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 64)) - 32'd32;
      1: return 32'(b[$urandom_range(0, 11)]);
      2: return 32'($urandom_range(0, 8191)) - 32'd4096;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; clear = 0; in_valid = 0; op_class = 0; alu_op = 0;
    rd = 0; rs1 = 0; rs2 = 0; imm = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst.valid", 32'(out_valid), 0);
    check_eq("rst.instr", out_instr, 0);
    check_eq("rst.addr", 32'(out_addr), 0);
    check_eq("rst.err", 32'(err), 0);
    check_eq("rst.code", 32'(err_code), 0);
    check_eq("rst.in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // directed encodings and address wrap
    cycle("add", 1, 0, 0, 3, 1, 2, 0, 0, 0);
    check_eq("add.word", out_instr, 32'h002081B3);
    check_eq("add.at", 32'(out_addr), 0);
    cycle("sub", 1, 0, 1, 3, 1, 2, 0, 1, 0);
    check_eq("sub.word", out_instr, 32'h402081B3);
    check_eq("sub.at", 32'(out_addr), 1);
    cycle("addi", 1, 1, 0, 5, 0, 0, 32'hFFFF_FFFF, 1, 0);
    check_eq("addi.word", out_instr, 32'hFFF00293);
    cycle("sw", 1, 3, 0, 0, 1, 2, 8, 1, 0);
    check_eq("sw.word", out_instr, 32'h0020A423);
    check_eq("sw.at", 32'(out_addr), 3);
    cycle("beq", 1, 4, 0, 0, 1, 2, 32'hFFFF_FFFC, 1, 0);
    check_eq("beq.word", out_instr, 32'hFE208EE3);
    check_eq("wrap.at", 32'(out_addr), 0);
    cycle("jalr", 1, 6, 0, 1, 5, 0, 0, 1, 0);
    check_eq("jalr.word", out_instr, 32'h000280E7);
    check_eq("jalr.at", 32'(out_addr), 1);
    cycle("drain", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("drain.valid", 32'(out_valid), 0);

    // errors: range then misaligned keeps the first code
    cycle("range", 1, 1, 0, 1, 1, 0, 2048, 1, 0);
    check_eq("range.valid", 32'(out_valid), 0);
    check_eq("range.code", 32'(err_code), 2);
    cycle("misal", 1, 4, 0, 0, 1, 2, 3, 1, 0);
    check_eq("misal.code", 32'(err_code), 2);
    check_eq("misal.err", 32'(err), 1);

    // back-pressure: first word held, second waits
    cycle("stallA", 1, 0, 0, 7, 8, 9, 0, 0, 0);
    cycle("stallB", 1, 0, 3, 7, 8, 9, 0, 0, 0);
    check_eq("stall.held", out_instr, 32'h009403B3);
    check_eq("stall.ready", 32'(in_ready), 0);
    cycle("stallB2", 1, 0, 3, 7, 8, 9, 0, 0, 0);
    cycle("drainB", 1, 0, 3, 7, 8, 9, 0, 1, 0);
    check_eq("second.word", out_instr, 32'h009463B3);
    check_eq("second.at", 32'(out_addr), 3);

    // clear beats a pending request
    cycle("clear", 1, 0, 0, 1, 1, 1, 0, 0, 1);
    check_eq("clear.valid", 32'(out_valid), 0);
    check_eq("clear.addr", 32'(out_addr), 0);
    check_eq("clear.err", 32'(err), 0);

    // asynchronous reset with a word pending
    cycle("prerst", 1, 2, 0, 4, 4, 0, 16, 0, 0);
    cycle("prerst2", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("prerst3", 1, 5, 0, 4, 0, 0, 32'h800, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst.valid", 32'(out_valid), 0);
    check_eq("arst.addr", 32'(out_addr), 0);
    check_eq("arst.instr", out_instr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      cycle("rand", $urandom_range(0, 3) != 0, c, 2'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), pick_imm(), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
